// File: rtl/fc0_mm_ctrl.sv
// -----------------------------------------------------------------------------
// fc0_mm_ctrl
// Controller for the two-bank matching memory (MMU0/MMU1) of firing-control
// stage FC0. It tracks how full each bank is, picks the bank for each store,
// power-gates each bank with a wake latency, and reports full/empty/next-write
// status back to the stage.
//
// Optional feature macro: FC0_MM_STAT_EN
//   defined   : 16-bit saturating accepted-store and stalled-cycle counters
//   undefined : stat_store_o / stat_stall_o tied to 0, no stat registers
//
// Handshake: a store is transferred on a rising clk edge where
// st_vld_i & st_rdy_o. st_vld_i may be held while st_rdy_o is low, and a
// store pulse that sees st_rdy_o low has no effect. rel_vld_i is a one-cycle
// release with no back-pressure.
//
// Ports:
//   clk            stage clock
//   rst            asynchronous active-low reset
//   mm16_i         1 = single-bank mode, only MMU0 takes new stores
//   st_vld_i       store request
//   st_rdy_o       store accepted when st_vld_i & st_rdy_o
//   st_bank_o      bank receiving the current store (0=MMU0, 1=MMU1)
//   rel_vld_i      one entry released
//   rel_bank_i     bank of the released entry
//   pg_mmu0_o      MMU0 power enable
//   pg_mmu1_o      MMU1 power enable
//   next_mmu0_w_o  next store targets MMU0
//   next_mmu1_w_o  next store targets MMU1
//   mm_full_o      no bank can accept a store
//   mmu0_empty_o   MMU0 occupancy is zero
//   mmu1_empty_o   MMU1 occupancy is zero
//   cnt0_o         MMU0 occupancy
//   cnt1_o         MMU1 occupancy
//   err_o          sticky: a release hit an empty bank
//   stat_store_o   accepted-store count
//   stat_stall_o   stalled-store cycle count
// -----------------------------------------------------------------------------
module fc0_mm_ctrl #(
    parameter int DEPTH_W  = 4,
    parameter int WAKE_CYC = 4,
    parameter int IDLE_CYC = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mm16_i,
    input  logic               st_vld_i,
    output logic               st_rdy_o,
    output logic               st_bank_o,
    input  logic               rel_vld_i,
    input  logic               rel_bank_i,
    output logic               pg_mmu0_o,
    output logic               pg_mmu1_o,
    output logic               next_mmu0_w_o,
    output logic               next_mmu1_w_o,
    output logic               mm_full_o,
    output logic               mmu0_empty_o,
    output logic               mmu1_empty_o,
    output logic [DEPTH_W:0]   cnt0_o,
    output logic [DEPTH_W:0]   cnt1_o,
    output logic               err_o,
    output logic [15:0]        stat_store_o,
    output logic [15:0]        stat_stall_o
);

    localparam int CW = DEPTH_W + 1;
    localparam logic [CW-1:0] CAP = CW'(2 ** DEPTH_W);

    typedef enum logic [1:0] {
        PWR_OFF  = 2'd0,
        PWR_WAKE = 2'd1,
        PWR_ON   = 2'd2
    } pwr_state_e;

    // Per-bank state, index 0 = MMU0, 1 = MMU1. pwr_q is the power FSM state.
    pwr_state_e    pwr_q [2];
    pwr_state_e    pwr_d [2];
    logic [7:0]    wake_q[2];
    logic [7:0]    wake_d[2];
    logic [7:0]    idle_q[2];
    logic [7:0]    idle_d[2];
    logic          pg_q  [2];
    logic          pg_d  [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          err_q;
    logic          err_d;

    logic          sel0;
    logic          sel1;
    logic          full;
    logic          bank;
    logic          rdy;
    logic          acc;
    logic [1:0]    inc;
    logic [1:0]    dec;
    logic [1:0]    demand;

    always_comb begin
        // Selection runs on registered counts only, so mm16_i changes apply
        // from the next evaluation without any flush.
        sel0 = cnt_q[0] < CAP;
        sel1 = !sel0 && !mm16_i && (cnt_q[1] < CAP);
        full = !sel0 && !sel1;
        bank = sel1;
        // A sleeping or waking target stalls; the store is never redirected.
        rdy  = !full && (pwr_q[bank] == PWR_ON);
        acc  = st_vld_i && rdy;

        err_d = err_q;
        for (int b = 0; b < 2; b++) begin
            inc[b]    = acc && (bank == 1'(b));
            dec[b]    = rel_vld_i && (rel_bank_i == 1'(b));
            demand[b] = (st_vld_i && (bank == 1'(b))) || (cnt_q[b] != '0);

            // Store and release together cancel; release on empty saturates.
            cnt_d[b] = cnt_q[b];
            if (inc[b] && !dec[b]) begin
                cnt_d[b] = cnt_q[b] + CW'(1);
            end else if (!inc[b] && dec[b] && (cnt_q[b] != '0)) begin
                cnt_d[b] = cnt_q[b] - CW'(1);
            end
            if (dec[b] && (cnt_q[b] == '0)) begin
                err_d = 1'b1;
            end

            pwr_d[b]  = pwr_q[b];
            wake_d[b] = wake_q[b];
            idle_d[b] = idle_q[b];
            case (pwr_q[b])
                PWR_OFF: begin
                    idle_d[b] = 8'd0;
                    if (demand[b]) begin
                        pwr_d[b]  = PWR_WAKE;
                        wake_d[b] = 8'(WAKE_CYC - 1);
                    end
                end
                PWR_WAKE: begin
                    idle_d[b] = 8'd0;
                    if (wake_q[b] == 8'd0) begin
                        pwr_d[b] = PWR_ON;
                    end else begin
                        wake_d[b] = wake_q[b] - 8'd1;
                    end
                end
                PWR_ON: begin
                    // demand includes cnt>0, so an occupied bank never idles off.
                    if (demand[b]) begin
                        idle_d[b] = 8'd0;
                    end else if (idle_q[b] + 8'd1 == 8'(IDLE_CYC)) begin
                        pwr_d[b]  = PWR_OFF;
                        idle_d[b] = 8'd0;
                    end else begin
                        idle_d[b] = idle_q[b] + 8'd1;
                    end
                end
                default: begin
                    pwr_d[b]  = PWR_OFF;
                    idle_d[b] = 8'd0;
                end
            endcase
            pg_d[b] = (pwr_d[b] != PWR_OFF);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                pwr_q[b]  <= PWR_OFF;
                wake_q[b] <= 8'd0;
                idle_q[b] <= 8'd0;
                pg_q[b]   <= 1'b0;
                cnt_q[b]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                pwr_q[b]  <= pwr_d[b];
                wake_q[b] <= wake_d[b];
                idle_q[b] <= idle_d[b];
                pg_q[b]   <= pg_d[b];
                cnt_q[b]  <= cnt_d[b];
            end
            err_q <= err_d;
        end
    end

    assign st_rdy_o      = rdy;
    assign st_bank_o     = bank;
    assign pg_mmu0_o     = pg_q[0];
    assign pg_mmu1_o     = pg_q[1];
    assign next_mmu0_w_o = sel0;
    assign next_mmu1_w_o = sel1;
    assign mm_full_o     = full;
    assign mmu0_empty_o  = (cnt_q[0] == '0);
    assign mmu1_empty_o  = (cnt_q[1] == '0);
    assign cnt0_o        = cnt_q[0];
    assign cnt1_o        = cnt_q[1];
    assign err_o         = err_q;

`ifdef FC0_MM_STAT_EN
    logic [15:0] stat_store_q;
    logic [15:0] stat_store_d;
    logic [15:0] stat_stall_q;
    logic [15:0] stat_stall_d;

    always_comb begin
        stat_store_d = stat_store_q;
        stat_stall_d = stat_stall_q;
        if (acc && (stat_store_q != 16'hFFFF)) begin
            stat_store_d = stat_store_q + 16'd1;
        end
        if (st_vld_i && !rdy && (stat_stall_q != 16'hFFFF)) begin
            stat_stall_d = stat_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_store_q <= 16'd0;
            stat_stall_q <= 16'd0;
        end else begin
            stat_store_q <= stat_store_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_store_o = stat_store_q;
    assign stat_stall_o = stat_stall_q;
`else
    assign stat_store_o = 16'd0;
    assign stat_stall_o = 16'd0;
`endif

endmodule
